comparator_rr_scheduler: RTL
============================

// Module: comparator_rr_scheduler
// PURPOSE
//  Shares one external W-bit magnitude comparator (lt/gt/eq outputs) among N
//  requesters. A round-robin arbiter picks one pending request, latches that
//  requester's operands onto the shared comparator bus and registers the
//  result. It then returns the result to the winner with a one-cycle done pulse.
//  Sits between the requesting datapath blocks and the single comparator instance.
// PARAMETERS
//  N  4  number of requesters (2..8)
//  W  4  operand width in bits; matches the comparator width
// PORTS
//  clk     in   1    system clock, rising edge
//  rst     in   1    asynchronous reset, active-high
//  req     in   N    level request per requester; bit i = requester i
//  a_in    in   N*W  operand A per requester; requester i at [i*W +: W]
//  b_in    in   N*W  operand B per requester; same packing as a_in
//  gnt     out  N    one-hot grant; high from DRIVE through DONE
//  done    out  N    one-cycle pulse to the winner in DONE; res_* valid then
//  res_lt  out  1    registered A<B of the last completed transaction
//  res_gt  out  1    registered A>B
//  res_eq  out  1    registered A==B
//  busy    out  1    high whenever state != IDLE
//  cmp_a   out  W    operand A to the shared comparator (registered)
//  cmp_b   out  W    operand B to the shared comparator (registered)
//  cmp_lt  in   1    comparator A<B result
//  cmp_gt  in   1    comparator A>B result
//  cmp_eq  in   1    comparator A==B result
//  txn_cnt out  8    completed-transaction count (only with CMP_TXN_COUNT_EN)
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE. gnt, done, res_*, cmp_a, cmp_b,
//    busy and txn_cnt all 0. Round-robin pointer ptr=N-1, so requester 0
//    has first priority.
//  - FSM: IDLE -> DRIVE -> DONE -> IDLE. Every transition takes exactly 1 cycle,
//    except IDLE, which holds until |req.
//  - IDLE: if |req, pick winner w = first set req bit searching ptr+1, ptr+2,
//    ..., wrapping modulo N. On that edge, load cmp_a/cmp_b from a_in/b_in[w],
//    set gnt=onehot(w) and go to DRIVE. If req==0, stay in IDLE; all outputs hold.
//  - DRIVE: operands are stable on the comparator for one full cycle. On the
//    exit edge, register res_lt/gt/eq <= cmp_lt/gt/eq (raw, no correction).
//    Set done=onehot(w), set ptr=w, go to DONE.
//  - DONE: done and gnt held for this single cycle. On the exit edge, clear
//    done and gnt and go to IDLE.
//  - Latency: IDLE sampling edge to done high = 2 edges. Peak throughput is
//    1 transaction per 3 cycles.
//  - Operands are sampled only at the grant edge. Later changes to a_in/b_in
//    do not affect the transaction in flight.
//  - A requester deasserts req in its done cycle to avoid re-arbitration. If
//    req stays high, it competes again and rotation still moves past it.
//  - If req is withdrawn while granted, the transaction completes and done
//    still pulses.
//  - Simultaneous requests: exactly one grant. Wrap-around: ptr=N-1 searches
//    from bit 0.
//  - res_* hold their value until the next DRIVE exit; they do not clear in IDLE.
//  - Reset mid-transaction aborts it: no done pulse, and ptr returns to N-1.
// CONFIGURATION
//  CMP_TXN_COUNT_EN defined: txn_cnt (8 bits) increments on every DRIVE->DONE
//    edge, wraps 255->0, and is cleared by rst.
//  CMP_TXN_COUNT_EN undefined: no counter logic; txn_cnt is tied to 8'd0.
// TESTING
//  1. Single request: req=0001, A0=2, B0=5 -> gnt=0001, cmp_a=2, cmp_b=5;
//     done=0001 two edges later with lt=1, gt=0, eq=0.
//  2. All requesters asserted after reset with (8,7),(12,12),(2,5),(7,8) ->
//     grant order 0,1,2,3,0. Results gt, eq, lt, lt; one done per 3 cycles.
//  3. Wrap-around: after requester 3 is served, req=1001 -> requester 0 wins
//     next, then requester 3.
//  4. Operand change: A1=8, B1=7 granted; change A1 to 0 during DRIVE ->
//     cmp_a stays 8 and the result is gt=1.
//  5. Reset asserted during DRIVE -> all outputs 0 at once, no done; next
//     req=1111 grants requester 0.
//  6. With CMP_TXN_COUNT_EN: 257 transactions -> txn_cnt=1. Without it,
//     txn_cnt stays 0 throughout.

Source files
------------

// File: rtl/comparator_rr_scheduler.sv
// Round-robin scheduler sharing one external W-bit magnitude comparator among N requesters.
// Optional completed-transaction counter on txn_cnt is enabled by defining CMP_TXN_COUNT_EN.
module comparator_rr_scheduler #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           res_lt,
  output logic           res_gt,
  output logic           res_eq,
  output logic           busy,
  output logic [W-1:0]   cmp_a,
  output logic [W-1:0]   cmp_b,
  input  logic           cmp_lt,
  input  logic           cmp_gt,
  input  logic           cmp_eq,
  output logic [7:0]     txn_cnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_q, win_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          res_lt_q, res_lt_d;
  logic          res_gt_q, res_gt_d;
  logic          res_eq_q, res_eq_d;
  logic [W-1:0]  cmp_a_q, cmp_a_d;
  logic [W-1:0]  cmp_b_q, cmp_b_d;

  logic          found;
  logic [PW-1:0] win_idx;
  logic [W-1:0]  sel_a, sel_b;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr_q) + k) % N) == i)) begin
          found   = 1'b1;
          win_idx = PW'(i);
        end
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) begin
        sel_a = a_in[i*W +: W];
        sel_b = b_in[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    res_lt_d = res_lt_q;
    res_gt_d = res_gt_q;
    res_eq_d = res_eq_q;
    cmp_a_d  = cmp_a_q;
    cmp_b_d  = cmp_b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          win_d   = win_idx;
          cmp_a_d = sel_a;
          cmp_b_d = sel_b;
          gnt_d   = N'(1) << win_idx;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Comparator outputs are taken as-is after a full cycle of stable operands.
        res_lt_d = cmp_lt;
        res_gt_d = cmp_gt;
        res_eq_d = cmp_eq;
        done_d   = gnt_q;
        ptr_d    = win_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done_d  = '0;
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_RST;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      res_lt_q <= 1'b0;
      res_gt_q <= 1'b0;
      res_eq_q <= 1'b0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      res_lt_q <= res_lt_d;
      res_gt_q <= res_gt_d;
      res_eq_q <= res_eq_d;
      cmp_a_q  <= cmp_a_d;
      cmp_b_q  <= cmp_b_d;
    end
  end

`ifdef CMP_TXN_COUNT_EN
  logic [7:0] txn_cnt_q, txn_cnt_d;

  // Counts DRIVE->DONE edges; free-running 8-bit wrap is intended.
  always_comb begin
    txn_cnt_d = txn_cnt_q;
    if (state_q == ST_DRIVE) begin
      txn_cnt_d = txn_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_cnt_q <= 8'd0;
    end else begin
      txn_cnt_q <= txn_cnt_d;
    end
  end

  assign txn_cnt = txn_cnt_q;
`else
  assign txn_cnt = 8'd0;
`endif

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign res_lt = res_lt_q;
  assign res_gt = res_gt_q;
  assign res_eq = res_eq_q;
  assign cmp_a  = cmp_a_q;
  assign cmp_b  = cmp_b_q;
  assign busy   = (state_q != ST_IDLE);

endmodule
